// File: rtl/arb_pkg.sv
// Shared definitions for the arbiter request queue and the arbiter bench checkers:
// client index width, client index type and the grant one-hot legality helper.
package arb_pkg;

  localparam int MAX_CLIENTS = 64;
  localparam int DEF_CLIENTS = 8;

  function automatic int client_id_w(input int clients);
    return $clog2(clients);
  endfunction

  typedef logic [client_id_w(DEF_CLIENTS)-1:0] client_idx_t;

  // Callers zero-extend narrower buses into the MAX_CLIENTS-wide argument.
  function automatic logic onehot_legal(input logic [MAX_CLIENTS-1:0] v);
    return $countones(v) == 1;
  endfunction

endpackage

// File: rtl/arb_client_fifo.sv
// Single-clock DEPTH x DATA_W FIFO for one arbiter client.
// DEPTH must be a power of two so the pointers wrap naturally.
module arb_client_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    cnt_q, cnt_d;
  logic              push_en, pop_en;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (push_en && !pop_en)      cnt_d = cnt_q + 1'b1;
    else if (!push_en && pop_en) cnt_d = cnt_q - 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: storage is not reset; occupancy is tracked by cnt_q, so stale contents are never read.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/arb_req_queue.sv
// Per-client request queues feeding a round-robin arbiter; pops the granted head.
// Optional starvation flags are built only when ARB_REQ_QUEUE_STARVE_EN is defined.
module arb_req_queue
  import arb_pkg::*;
#(
  parameter int CLIENTS = 8,
  parameter int DEPTH   = 4,
  parameter int DATA_W  = 32
`ifdef ARB_REQ_QUEUE_STARVE_EN
  ,
  parameter int STARVE_LIMIT = 16
`endif
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [CLIENTS-1:0]            push_valid,
  input  logic [CLIENTS*DATA_W-1:0]     push_data,
  output logic [CLIENTS-1:0]            push_ready,
  output logic [CLIENTS-1:0]            request,
  input  logic [CLIENTS-1:0]            grant,
  output logic                          out_valid,
  output logic [DATA_W-1:0]             out_data,
  output logic [client_id_w(CLIENTS)-1:0] out_client,
  output logic                          grant_err
`ifdef ARB_REQ_QUEUE_STARVE_EN
  ,
  output logic [CLIENTS-1:0]            starve
`endif
);

  localparam int CID_W = client_id_w(CLIENTS);

  logic [DATA_W-1:0]      fifo_dout [CLIENTS];
  logic [CLIENTS-1:0]     full, empty, pop;
  logic [MAX_CLIENTS-1:0] grant_ext;
  logic                   grant_legal, grant_illegal;
  logic [CID_W-1:0]       grant_idx;
  logic [DATA_W-1:0]      head_data;

  logic                   out_valid_q;
  logic [DATA_W-1:0]      out_data_q;
  logic [CID_W-1:0]       out_client_q;
  logic                   grant_err_q;

  for (genvar i = 0; i < CLIENTS; i++) begin : g_fifo
    arb_client_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
      .clk    (clock),
      .rst_n  (reset_n),
      .push_i (push_valid[i]),
      .data_i (push_data[i*DATA_W +: DATA_W]),
      .pop_i  (pop[i]),
      .data_o (fifo_dout[i]),
      .full_o (full[i]),
      .empty_o(empty[i])
    );
  end

  assign push_ready = ~full;
  assign request    = ~empty;

  // A grant is legal only when one-hot and aimed at a client that is requesting.
  always_comb begin
    grant_ext                = '0;
    grant_ext[CLIENTS-1:0]   = grant;
    grant_legal   = onehot_legal(grant_ext) && |(grant & request);
    grant_illegal = |grant && !grant_legal;
    pop           = grant_legal ? grant : '0;
  end

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < CLIENTS; i++) begin
      if (grant[i]) grant_idx = CID_W'(i);
    end
    head_data = fifo_dout[grant_idx];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_client_q <= '0;
      grant_err_q  <= 1'b0;
    end else begin
      out_valid_q <= grant_legal;
      grant_err_q <= grant_err_q | grant_illegal;
      if (grant_legal) begin
        out_data_q   <= head_data;
        out_client_q <= grant_idx;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_client = out_client_q;
  assign grant_err  = grant_err_q;

`ifdef ARB_REQ_QUEUE_STARVE_EN
  localparam int              SW      = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]   LIMIT_V = SW'(STARVE_LIMIT);

  logic [SW-1:0]      wait_q [CLIENTS];
  logic [SW-1:0]      wait_d [CLIENTS];
  logic [CLIENTS-1:0] starve_q;

  // Counts cycles a requesting client goes ungranted; saturates at the limit.
  always_comb begin
    for (int i = 0; i < CLIENTS; i++) begin
      wait_d[i] = wait_q[i];
      if (!request[i] || pop[i])                  wait_d[i] = '0;
      else if (!grant[i] && wait_q[i] != LIMIT_V) wait_d[i] = wait_q[i] + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CLIENTS; i++) wait_q[i] <= '0;
      starve_q <= '0;
    end else begin
      for (int i = 0; i < CLIENTS; i++) begin
        wait_q[i]   <= wait_d[i];
        starve_q[i] <= (wait_d[i] == LIMIT_V);
      end
    end
  end

  assign starve = starve_q;
`endif

endmodule

// File: tb/tb_arb_req_queue.sv
// Directed self-checking bench for arb_req_queue (8 clients, depth 4, 32-bit data).
// Starvation checks are compiled in only when ARB_REQ_QUEUE_STARVE_EN is defined.
module tb_arb_req_queue;
  import arb_pkg::*;

  logic          clock;
  logic          reset_n;
  logic [7:0]    push_valid;
  logic [255:0]  push_data;
  logic [7:0]    push_ready;
  logic [7:0]    request;
  logic [7:0]    grant;
  logic          out_valid;
  logic [31:0]   out_data;
  client_idx_t   out_client;
  logic          grant_err;
`ifdef ARB_REQ_QUEUE_STARVE_EN
  logic [7:0]    starve;
`endif

  int n_checks = 0;
  int n_errors = 0;

  arb_req_queue #(.CLIENTS(8), .DEPTH(4), .DATA_W(32)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .push_valid(push_valid),
    .push_data (push_data),
    .push_ready(push_ready),
    .request   (request),
    .grant     (grant),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_client(out_client),
    .grant_err (grant_err)
`ifdef ARB_REQ_QUEUE_STARVE_EN
    ,
    .starve    (starve)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One clock cycle with the given push mask (single client c carries data d) and grant.
  task automatic drive(input logic [7:0] pv, input int c, input logic [31:0] d,
                       input logic [7:0] g);
    push_valid = pv;
    push_data  = '0;
    if (pv != 8'h00) push_data[c*32 +: 32] = d;
    grant = g;
    tick();
    push_valid = '0;
    push_data  = '0;
    grant      = '0;
  endtask

  initial begin
    reset_n    = 1'b0;
    push_valid = '0;
    push_data  = '0;
    grant      = '0;
    #1;
    check("rst_request",    64'(request),    64'h00);
    check("rst_push_ready", 64'(push_ready), 64'hFF);
    check("rst_out_valid",  64'(out_valid),  64'h0);
    check("rst_out_data",   64'(out_data),   64'h0);
    check("rst_out_client", 64'(out_client), 64'h0);
    check("rst_grant_err",  64'(grant_err),  64'h0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Single client: push to client 3, grant it, observe the registered output.
    drive(8'h08, 3, 32'hA5, 8'h00);
    check("single_request", 64'(request), 64'h08);
    drive(8'h00, 0, 32'h0, 8'h08);
    check("single_valid",   64'(out_valid),  64'h1);
    check("single_data",    64'(out_data),   64'hA5);
    check("single_client",  64'(out_client), 64'h3);
    check("single_req_low", 64'(request),    64'h00);
    tick();
    check("idle_valid_low", 64'(out_valid), 64'h0);
    check("idle_data_hold", 64'(out_data),  64'hA5);

    // Full and wrap on client 0.
    for (int k = 0; k < 4; k++) drive(8'h01, 0, 32'h100 + 32'(k), 8'h00);
    check("full_ready_low", 64'(push_ready), 64'hFE);
    drive(8'h01, 0, 32'h104, 8'h00);
    check("full_drop_req",  64'(request),    64'h01);
    for (int k = 0; k < 4; k++) begin
      drive(8'h00, 0, 32'h0, 8'h01);
      check("drain_valid", 64'(out_valid),  64'h1);
      check("drain_data",  64'(out_data),   64'h100 + 64'(k));
      check("drain_client", 64'(out_client), 64'h0);
    end
    check("drain_req_low",  64'(request),    64'h00);
    check("drain_ready",    64'(push_ready), 64'hFF);
    for (int k = 0; k < 3; k++) drive(8'h01, 0, 32'h200 + 32'(k), 8'h00);
    for (int k = 0; k < 3; k++) begin
      drive(8'h01, 0, 32'h203 + 32'(k), 8'h01);
      check("wrap_pp_data", 64'(out_data), 64'h200 + 64'(k));
    end
    for (int k = 0; k < 3; k++) begin
      drive(8'h00, 0, 32'h0, 8'h01);
      check("wrap_data", 64'(out_data), 64'h203 + 64'(k));
    end
    check("wrap_req_low", 64'(request), 64'h00);

    // Simultaneous push and pop on client 1 holding two entries.
    drive(8'h02, 1, 32'h11, 8'h00);
    drive(8'h02, 1, 32'h12, 8'h00);
    drive(8'h02, 1, 32'h13, 8'h02);
    check("pp_data",    64'(out_data),   64'h11);
    check("pp_client",  64'(out_client), 64'h1);
    check("pp_request", 64'(request),    64'h02);
    drive(8'h00, 0, 32'h0, 8'h02);
    check("pp_next",    64'(out_data),   64'h12);
    drive(8'h00, 0, 32'h0, 8'h02);
    check("pp_last",    64'(out_data),   64'h13);
    check("pp_empty",   64'(request),    64'h00);
    check("pp_no_err",  64'(grant_err),  64'h0);

    // Illegal grants: multi-hot, then a grant to a non-requesting client.
    drive(8'h02, 1, 32'h21, 8'h00);
    drive(8'h04, 2, 32'h22, 8'h00);
    check("ill_request", 64'(request), 64'h06);
    drive(8'h00, 0, 32'h0, 8'h06);
    check("ill_multi_valid", 64'(out_valid), 64'h0);
    check("ill_multi_err",   64'(grant_err), 64'h1);
    check("ill_multi_nopop", 64'(request),   64'h06);
    check("ill_data_hold",   64'(out_data),  64'h13);
    drive(8'h00, 0, 32'h0, 8'h10);
    check("ill_norq_valid",  64'(out_valid), 64'h0);
    check("ill_norq_err",    64'(grant_err), 64'h1);
    check("ill_norq_nopop",  64'(request),   64'h06);
    drive(8'h00, 0, 32'h0, 8'h02);
    check("ill_after_data",  64'(out_data),   64'h21);
    check("ill_after_cli",   64'(out_client), 64'h1);
    drive(8'h00, 0, 32'h0, 8'h04);
    check("ill_after_data2", 64'(out_data),   64'h22);
    check("ill_after_cli2",  64'(out_client), 64'h2);
    check("ill_err_sticky",  64'(grant_err),  64'h1);

    // Reset mid-traffic with three entries queued on client 2.
    for (int k = 0; k < 3; k++) drive(8'h04, 2, 32'h31 + 32'(k), 8'h00);
    drive(8'h00, 0, 32'h0, 8'h04);
    check("mid_pre_valid", 64'(out_valid), 64'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_request", 64'(request),    64'h00);
    check("mid_rst_ready",   64'(push_ready), 64'hFF);
    check("mid_rst_valid",   64'(out_valid),  64'h0);
    check("mid_rst_err",     64'(grant_err),  64'h0);
    tick();
    reset_n = 1'b1;
    tick();
    check("mid_post_request", 64'(request), 64'h00);
    tick();
    check("mid_post_valid",   64'(out_valid), 64'h0);

`ifdef ARB_REQ_QUEUE_STARVE_EN
    // Starvation on client 5 with the default limit of 16.
    drive(8'h20, 5, 32'h55, 8'h00);
    check("starve_req", 64'(request), 64'h20);
    for (int k = 0; k < 15; k++) tick();
    check("starve_before", 64'(starve), 64'h00);
    tick();
    check("starve_set", 64'(starve), 64'h20);
    tick();
    check("starve_hold", 64'(starve), 64'h20);
    drive(8'h00, 0, 32'h0, 8'h20);
    check("starve_clear", 64'(starve),   64'h00);
    check("starve_data",  64'(out_data), 64'h55);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
